// File: rtl/t65_bus_pkg.sv
// ---------------------------------------------------------------------------
// t65_bus_pkg
// Shared types and constants for the T65 memory-mapped bus target.
//   t65_tgt_state_t : bus target FSM state (IDLE, REQ, DONE)
//   T65_TMO_W       : width of the REQ-phase timeout counter
//   T65_ERR_DATA    : read data returned to the CPU after a backend timeout
// ---------------------------------------------------------------------------
package t65_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } t65_tgt_state_t;

    localparam int         T65_TMO_W    = 8;
    localparam logic [7:0] T65_ERR_DATA = 8'hFF;

endpackage

// File: rtl/t65_wr_buffer.sv
// ---------------------------------------------------------------------------
// t65_wr_buffer
// Single-entry posted-write buffer (address, data, valid).
// Used by t65_bus_target only when T65_BUS_TARGET_POSTED_WR_EN is defined.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   push               : capture push_addr/push_data and mark the entry valid
//   pop                : release the entry once the backend has completed it
//   push_addr/push_data: write to be posted
//   valid, addr, data  : current entry
// ---------------------------------------------------------------------------
module t65_wr_buffer #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_BITS-1:0] push_addr,
    input  logic [7:0]           push_data,
    output logic                 valid,
    output logic [ADDR_BITS-1:0] addr,
    output logic [7:0]           data
);

    logic                 r_valid;
    logic [ADDR_BITS-1:0] r_addr;
    logic [7:0]           r_data;

    // NOTE: a single entry is cheap flops, so address and data get reset
    // along with the valid flag; a deep RAM would reset only its valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (push) begin
            r_valid <= 1'b1;
            r_addr  <= push_addr;
            r_data  <= push_data;
        end else if (pop) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign addr  = r_addr;
    assign data  = r_data;

endmodule

// File: rtl/t65_bus_target.sv
// ---------------------------------------------------------------------------
// t65_bus_target
// Slave responder on the T65 (6502-mode) CPU bus. A valid access inside the
// aligned window [BASE_ADDR, BASE_ADDR + 2^ADDR_BITS) is turned into one
// req/ack transaction on a slow backend port; the CPU is held with rdy=0
// until the backend answers (or the REQ phase times out).
//
// Parameters: BASE_ADDR (window base), ADDR_BITS (window size log2),
//             TIMEOUT (max REQ cycles before abort, 0 = never).
// Ports:
//   clk, rst_n, enable           : clock, async active-low reset, CPU clk enable
//   addr, r_not_w, vda, vpa      : CPU address / direction / valid strobes
//   data_i, data_o, data_oe      : CPU write data, read data, tristate enable
//   rdy                          : CPU ready (0 = stall), wire-AND at top level
//   be_req, be_we, be_addr,
//   be_wdata, be_ack, be_rdata   : backend request / completion
//   bus_err                      : sticky timeout flag
// Build option: define T65_BUS_TARGET_POSTED_WR_EN for zero-stall posted
// writes through a single-entry write buffer (t65_wr_buffer).
// ---------------------------------------------------------------------------
module t65_bus_target
    import t65_bus_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h8000,
    parameter int          ADDR_BITS = 12,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [15:0]          addr,
    input  logic                 r_not_w,
    input  logic                 vda,
    input  logic                 vpa,
    input  logic [7:0]           data_i,
    output logic [7:0]           data_o,
    output logic                 data_oe,
    output logic                 rdy,
    output logic                 be_req,
    output logic                 be_we,
    output logic [ADDR_BITS-1:0] be_addr,
    output logic [7:0]           be_wdata,
    input  logic                 be_ack,
    input  logic [7:0]           be_rdata,
    output logic                 bus_err
);

    localparam logic [T65_TMO_W-1:0] TMO_LIMIT = TIMEOUT[T65_TMO_W-1:0];
    localparam bit                   TMO_EN    = (TIMEOUT != 0);

    t65_tgt_state_t       r_state, w_state_next;
    logic [T65_TMO_W-1:0] r_cnt;
    logic [7:0]           r_data_o, r_be_wdata;
    logic                 r_be_req, r_be_we, r_bus_err;
    logic [ADDR_BITS-1:0] r_be_addr;

    logic                 w_hit, w_start, w_ack_take, w_tmo, w_finish;
    logic                 w_drain_start, w_is_drain, w_posted_rdy;
    logic [ADDR_BITS-1:0] w_drain_addr;
    logic [7:0]           w_drain_data;

    assign w_hit      = (vda | vpa) & (addr[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS]);
    // be_ack is only meaningful in REQ; a stray ack elsewhere falls out here.
    assign w_ack_take = (r_state == REQ) & be_ack;
    // Ack wins over a timeout that expires in the same cycle.
    assign w_tmo      = TMO_EN & (r_state == REQ) & ~be_ack & (r_cnt == TMO_LIMIT);
    assign w_finish   = w_ack_take | w_tmo;

`ifdef T65_BUS_TARGET_POSTED_WR_EN
    logic w_buf_valid, w_post, r_posted, r_drain;

    // A write hit is posted only once per CPU bus cycle: r_posted remembers
    // that this cycle was already captured until the enable edge ends it.
    assign w_post        = (r_state == IDLE) & ~w_buf_valid & w_hit & ~r_not_w & ~r_posted;
    // A pending buffer entry always drains before any new CPU access, which
    // keeps backend order equal to CPU order.
    assign w_drain_start = (r_state == IDLE) & w_buf_valid;
    assign w_start       = (r_state == IDLE) & ~w_buf_valid & w_hit & ~w_post & ~r_posted;
    assign w_is_drain    = r_drain;
    assign w_posted_rdy  = w_hit & ~r_not_w & (w_post | r_posted);

    t65_wr_buffer #(
        .ADDR_BITS (ADDR_BITS)
    ) u_wr_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_post),
        .pop       (w_finish & r_drain),
        .push_addr (addr[ADDR_BITS-1:0]),
        .push_data (data_i),
        .valid     (w_buf_valid),
        .addr      (w_drain_addr),
        .data      (w_drain_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_posted <= 1'b0;
            r_drain  <= 1'b0;
        end else begin
            if (enable)      r_posted <= 1'b0;
            else if (w_post) r_posted <= 1'b1;
            if (w_drain_start) r_drain <= 1'b1;
            else if (w_start)  r_drain <= 1'b0;
        end
    end
`else
    assign w_start       = (r_state == IDLE) & w_hit;
    assign w_drain_start = 1'b0;
    assign w_is_drain    = 1'b0;
    assign w_posted_rdy  = 1'b0;
    assign w_drain_addr  = '0;
    assign w_drain_data  = '0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: the next-state value is defaulted first so every path assigns it
    // and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_start | w_drain_start) w_state_next = REQ;
            // A background drain has no CPU cycle waiting, so skip DONE.
            REQ:  if (w_finish) w_state_next = w_is_drain ? IDLE : DONE;
            DONE: if (enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_o   <= '0;
            r_be_req   <= 1'b0;
            r_be_we    <= 1'b0;
            r_be_addr  <= '0;
            r_be_wdata <= '0;
            r_bus_err  <= 1'b0;
            r_cnt      <= '0;
        end else if (w_start) begin
            r_be_addr  <= addr[ADDR_BITS-1:0];
            r_be_we    <= ~r_not_w;
            r_be_wdata <= data_i;
            r_be_req   <= 1'b1;
            r_cnt      <= '0;
        end else if (w_drain_start) begin
            r_be_addr  <= w_drain_addr;
            r_be_we    <= 1'b1;
            r_be_wdata <= w_drain_data;
            r_be_req   <= 1'b1;
            r_cnt      <= '0;
        end else if (w_ack_take) begin
            r_be_req <= 1'b0;
            if (!r_be_we) r_data_o <= be_rdata;
        end else if (w_tmo) begin
            r_be_req  <= 1'b0;
            r_data_o  <= T65_ERR_DATA;
            r_bus_err <= 1'b1;
        end else if (r_state == REQ) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign rdy      = ~rst_n | ~w_hit | (r_state == DONE) | w_posted_rdy;
    assign data_oe  = w_hit & r_not_w & (r_state == DONE);
    assign data_o   = r_data_o;
    assign be_req   = r_be_req;
    assign be_we    = r_be_we;
    assign be_addr  = r_be_addr;
    assign be_wdata = r_be_wdata;
    assign bus_err  = r_bus_err;

endmodule

// File: tb/tb_t65_bus_target.sv
// ---------------------------------------------------------------------------
// tb_t65_bus_target
// Directed bench for t65_bus_target (default build, TIMEOUT=4). Stimulus
// pushes expected backend requests and CPU-cycle completions into queues;
// two monitors pop and compare when the DUT raises be_req or completes a
// CPU bus cycle.
// ---------------------------------------------------------------------------
module tb_t65_bus_target;

    localparam int AB = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [15:0]   addr;
    logic          r_not_w, vda, vpa;
    logic [7:0]    data_i, data_o;
    logic          data_oe, rdy;
    logic          be_req, be_we;
    logic [AB-1:0] be_addr;
    logic [7:0]    be_wdata;
    logic          be_ack;
    logic [7:0]    be_rdata;
    logic          bus_err;

    t65_bus_target #(
        .BASE_ADDR (16'h8000),
        .ADDR_BITS (AB),
        .TIMEOUT   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .addr     (addr),
        .r_not_w  (r_not_w),
        .vda      (vda),
        .vpa      (vpa),
        .data_i   (data_i),
        .data_o   (data_o),
        .data_oe  (data_oe),
        .rdy      (rdy),
        .be_req   (be_req),
        .be_we    (be_we),
        .be_addr  (be_addr),
        .be_wdata (be_wdata),
        .be_ack   (be_ack),
        .be_rdata (be_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AB-1:0] a;
        logic [7:0]    wd;
        logic          chk_wd;
        int            cycles;
    } be_exp_t;

    typedef struct {
        logic       oe;
        logic [7:0] d;
        logic       chk_d;
        logic       err;
        int         stall;
    } cpu_exp_t;

    be_exp_t  be_q[$];
    cpu_exp_t cpu_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic       cyc_active = 1'b0;
    int         bk_lat     = 1;      // REQ cycle (1-based) in which ack is given; 0 = never
    logic [7:0] bk_rdata   = 8'h00;
    logic       stray      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic queue_fault(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with no expected entry queued", name);
    endtask

    // Backend model: acks in the bk_lat-th cycle of a request.
    initial begin
        int cnt;
        cnt    = 0;
        be_ack = 1'b0;
        be_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n || !be_req) begin
                cnt    = 0;
                be_ack = stray;
            end else begin
                cnt++;
                be_ack = (bk_lat != 0) && (cnt == bk_lat);
            end
            be_rdata = bk_rdata;
        end
    end

    // Backend-request monitor.
    initial begin
        logic    prev;
        logic    have;
        int      cyc;
        be_exp_t cur;
        prev = 1'b0;
        have = 1'b0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            if (be_req) begin
                if (!prev) begin
                    cyc = 0;
                    if (be_q.size() == 0) begin
                        queue_fault("be_req");
                        have = 1'b0;
                    end else begin
                        cur  = be_q.pop_front();
                        have = 1'b1;
                        check("be_we", be_we, cur.we);
                        check("be_addr", be_addr, cur.a);
                        if (cur.chk_wd) check("be_wdata", be_wdata, cur.wd);
                    end
                end
                cyc++;
            end else if (prev && have) begin
                check("be_req_cycles", cyc, cur.cycles);
            end
            prev = be_req;
        end
    end

    // CPU-cycle monitor: a cycle completes on a negedge with rdy & enable.
    initial begin
        int       stall;
        cpu_exp_t e;
        stall = 0;
        forever begin
            @(negedge clk);
            if (rst_n && cyc_active) begin
                if (!rdy) begin
                    stall++;
                end else if (enable) begin
                    if (cpu_q.size() == 0) begin
                        queue_fault("cpu_cycle");
                    end else begin
                        e = cpu_q.pop_front();
                        check("stall_cycles", stall, e.stall);
                        check("data_oe", data_oe, e.oe);
                        if (e.chk_d) check("data_o", data_o, e.d);
                        check("bus_err", bus_err, e.err);
                        check("be_req_at_end", be_req, 1'b0);
                    end
                    stall = 0;
                end
            end
        end
    end

    task automatic push_be(input logic we, input logic [AB-1:0] a, input logic [7:0] wd,
                           input logic chk_wd, input int cycles);
        be_exp_t b;
        b.we = we; b.a = a; b.wd = wd; b.chk_wd = chk_wd; b.cycles = cycles;
        be_q.push_back(b);
    endtask

    task automatic push_cpu(input logic oe, input logic [7:0] d, input logic chk_d,
                            input logic err, input int stall);
        cpu_exp_t c;
        c.oe = oe; c.d = d; c.chk_d = chk_d; c.err = err; c.stall = stall;
        cpu_q.push_back(c);
    endtask

    // Drive one CPU bus cycle; called at posedge+1. enable stays low for
    // en_hold cycles to exercise DONE holding until an enable edge.
    task automatic cpu_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input logic va, input logic pa, input int en_hold);
        int n;
        addr = a; r_not_w = rw; data_i = wd; vda = va; vpa = pa;
        enable = (en_hold == 0);
        cyc_active = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (rdy && enable) break;
            n++;
            if (n > 60) begin
                check("cpu_cycle_budget", n, 0);
                break;
            end
            @(posedge clk);
            #1;
            if (n >= en_hold) enable = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc_active = 1'b0;
        vda = 1'b0; vpa = 1'b0; enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        rst_n = 1'b0; enable = 1'b1; addr = 16'h0000; r_not_w = 1'b1;
        vda = 1'b0; vpa = 1'b0; data_i = 8'h00;
        #2;
        check("rst_rdy", rdy, 1'b1);
        check("rst_be_req", be_req, 1'b0);
        check("rst_data_o", data_o, 8'h00);
        check("rst_bus_err", bus_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Read hit, ack in 3rd REQ cycle: 4 stall cycles.
        bk_lat = 3; bk_rdata = 8'h5A;
        push_be(1'b0, 12'h123, 8'h00, 1'b0, 3);
        push_cpu(1'b1, 8'h5A, 1'b1, 1'b0, 4);
        cpu_cycle(16'h8123, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Miss with a stray backend ack: nothing must change.
        stray = 1'b1; bk_rdata = 8'hEE;
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 0);
        cpu_cycle(16'h7FFF, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        stray = 1'b0;
        @(negedge clk);
        check("stray_data_o", data_o, 8'h5A);
        check("stray_be_req", be_req, 1'b0);
        @(posedge clk);
        #1;

        // Write hit at top of window, ack in first REQ cycle: minimum stall.
        bk_lat = 1;
        push_be(1'b1, 12'hFFF, 8'hC3, 1'b1, 1);
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 2);
        cpu_cycle(16'h8FFF, 1'b0, 8'hC3, 1'b1, 1'b0, 0);

        // In-window address but vda=vpa=0: miss.
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 0);
        cpu_cycle(16'h8123, 1'b1, 8'h00, 1'b0, 1'b0, 0);

        // Opcode fetch (vpa only), ack in 2nd REQ cycle.
        bk_lat = 2; bk_rdata = 8'h3C;
        push_be(1'b0, 12'h001, 8'h00, 1'b0, 2);
        push_cpu(1'b1, 8'h3C, 1'b1, 1'b0, 3);
        cpu_cycle(16'h8001, 1'b1, 8'h00, 1'b0, 1'b1, 0);

        // RMW double write, back to back.
        bk_lat = 1;
        push_be(1'b1, 12'h020, 8'h10, 1'b1, 1);
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 2);
        push_be(1'b1, 12'h020, 8'h20, 1'b1, 1);
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 2);
        cpu_cycle(16'h8020, 1'b0, 8'h10, 1'b1, 1'b0, 0);
        cpu_cycle(16'h8020, 1'b0, 8'h20, 1'b1, 1'b0, 0);

        // DONE must hold while enable is low.
        bk_lat = 2; bk_rdata = 8'h77;
        push_be(1'b0, 12'hABC, 8'h00, 1'b0, 2);
        push_cpu(1'b1, 8'h77, 1'b1, 1'b0, 3);
        cpu_cycle(16'h8ABC, 1'b1, 8'h00, 1'b1, 1'b0, 4);

        // Just above the window: miss.
        push_cpu(1'b0, 8'h00, 1'b0, 1'b0, 0);
        cpu_cycle(16'h9000, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Timeout: no ack, TIMEOUT=4 -> 5 REQ cycles, 0xFF, bus_err set.
        bk_lat = 0;
        push_be(1'b0, 12'h456, 8'h00, 1'b0, 5);
        push_cpu(1'b1, 8'hFF, 1'b1, 1'b1, 6);
        cpu_cycle(16'h8456, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        // Reset two cycles into REQ.
        bk_lat = 0;
        push_be(1'b0, 12'h200, 8'h00, 1'b0, 2);
        addr = 16'h8200; r_not_w = 1'b1; vda = 1'b1; vpa = 1'b0; data_i = 8'h00;
        k = 0;
        while (k < 10) begin
            @(negedge clk);
            if (be_req) break;
            k++;
        end
        check("rst_mid_req_seen", be_req, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_be_req", be_req, 1'b0);
        check("rst_mid_rdy", rdy, 1'b1);
        check("rst_mid_data_o", data_o, 8'h00);
        check("rst_mid_data_oe", data_oe, 1'b0);
        check("rst_mid_be_addr", be_addr, 12'h000);
        check("rst_mid_be_we", be_we, 1'b0);
        check("rst_mid_be_wdata", be_wdata, 8'h00);
        check("rst_mid_bus_err", bus_err, 1'b0);
        vda = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal read after release: back in IDLE.
        bk_lat = 1; bk_rdata = 8'hA5;
        push_be(1'b0, 12'h300, 8'h00, 1'b0, 1);
        push_cpu(1'b1, 8'hA5, 1'b1, 1'b0, 2);
        cpu_cycle(16'h8300, 1'b1, 8'h00, 1'b1, 1'b0, 0);

        repeat (4) @(negedge clk);
        check("be_queue_drained", be_q.size(), 0);
        check("cpu_queue_drained", cpu_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
